// File: rtl/bus_drive_sequencer_pkg.sv
// Shared types and helpers for the bus drive sequencer: FSM encoding and
// enable-to-vector expansion used to build per-channel drive slices.
package bus_drive_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TURN  = 2'd2
  } bds_state_e;

  // Widest drive slice the expansion helper supports.
  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] expand_en(input logic en);
    return {MAX_W{en}};
  endfunction

endpackage

// File: rtl/bus_drive_sequencer_if.sv
// Request/grant/drive bundle between bus masters and the drive sequencer.
interface bus_drive_sequencer_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
);
  logic [CHANNELS-1:0]       req;
  logic [CHANNELS-1:0]       grant;
  logic [CHANNELS*WIDTH-1:0] drive;
  logic                      bus_idle;
  logic                      preempt;

  modport master (output req, input grant, input drive, input bus_idle, input preempt);
  modport slave  (input req, output grant, output drive, output bus_idle, output preempt);
endinterface

// File: rtl/bus_drive_sequencer_rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or after ptr,
// wrapping modulo CHANNELS (works for non-power-of-two counts).
module rr_arbiter #(
  parameter int CHANNELS = 4,
  parameter int PW       = 2
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [PW-1:0]       ptr,
  output logic [CHANNELS-1:0] gnt,
  output logic [PW-1:0]       idx,
  output logic                vld
);
  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    // Walk offsets from farthest to nearest so the nearest hit wins.
    for (int k = CHANNELS-1; k >= 0; k--) begin
      int c;
      c = int'(ptr) + k;
      if (c >= CHANNELS) c = c - CHANNELS;
      if (req[c]) begin
        gnt    = '0;
        gnt[c] = 1'b1;
        idx    = PW'(c);
        vld    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bus_drive_sequencer.sv
// Shared-bus drive sequencer: one owner at a time, round-robin arbitration,
// enforced all-low turnaround gap between owners, optional hold-time preemption.
module bus_drive_sequencer
  import bus_drive_sequencer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int TURNAROUND = 1,
  parameter int HOLD_MAX   = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  bus_drive_sequencer_if.slave bus
);
  localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int TW = $clog2(TURNAROUND + 1);
  localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

  if (TURNAROUND < 1) begin : g_bad_turn
    $error("TURNAROUND must be at least 1");
  end
  if (CHANNELS < 2 || CHANNELS > 8) begin : g_bad_ch
    $error("CHANNELS must be in 2..8");
  end
  if (WIDTH < 1 || WIDTH > MAX_W) begin : g_bad_w
    $error("WIDTH out of supported range");
  end

  bds_state_e          state, state_d;
  logic [CHANNELS-1:0] grant_q, grant_d;
  logic [PW-1:0]       owner, owner_d, ptr, ptr_d;
  logic [HW-1:0]       hold, hold_d;
  logic [TW-1:0]       turn, turn_d;
  logic                preempt_q, preempt_d;
  logic                arb_go, pre_cond;
  logic [CHANNELS-1:0] arb_gnt;
  logic [PW-1:0]       arb_idx;
  logic                arb_vld;

  rr_arbiter #(.CHANNELS(CHANNELS), .PW(PW)) u_arb (
    .req(bus.req), .ptr(ptr), .gnt(arb_gnt), .idx(arb_idx), .vld(arb_vld)
  );

  always_comb begin
    state_d   = state;
    grant_d   = grant_q;
    owner_d   = owner;
    ptr_d     = ptr;
    hold_d    = hold;
    turn_d    = turn;
    preempt_d = 1'b0;
    arb_go    = 1'b0;
    pre_cond  = (HOLD_MAX != 0) && (hold == HOLD_LAST) && (|(bus.req & ~grant_q));
    case (state)
      ST_IDLE: arb_go = 1'b1;
      ST_DRIVE: begin
        if (!bus.req[owner] || pre_cond) begin
          grant_d   = '0;
          state_d   = ST_TURN;
          turn_d    = TW'(TURNAROUND - 1);
          ptr_d     = (owner == PW'(CHANNELS - 1)) ? '0 : owner + PW'(1);
          preempt_d = bus.req[owner];
        end else if (hold != '1) begin
          hold_d = hold + HW'(1);
        end
      end
      ST_TURN: begin
        if (turn == '0) arb_go = 1'b1;
        else            turn_d = turn - TW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    // IDLE and the final TURN cycle share the same arbitration step.
    if (arb_go) begin
      if (arb_vld) begin
        grant_d = arb_gnt;
        owner_d = arb_idx;
        hold_d  = '0;
        state_d = ST_DRIVE;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      grant_q   <= '0;
      owner     <= '0;
      ptr       <= '0;
      hold      <= '0;
      turn      <= '0;
      preempt_q <= 1'b0;
    end else begin
      state     <= state_d;
      grant_q   <= grant_d;
      owner     <= owner_d;
      ptr       <= ptr_d;
      hold      <= hold_d;
      turn      <= turn_d;
      preempt_q <= preempt_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.bus_idle = (state != ST_DRIVE);
  assign bus.preempt  = preempt_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_drv
    assign bus.drive[i*WIDTH +: WIDTH] = WIDTH'(expand_en(grant_q[i]));
  end
endmodule

// File: tb/tb_bus_drive_sequencer.sv
// Scoreboard bench: two configurations, per-cycle expected outputs queued by
// the stimulus process and checked by an independent monitor.
module tb_bus_drive_sequencer;
  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_c = 1'b0;
  always #5 clk = ~clk;

  bus_drive_sequencer_if #(.CHANNELS(4), .WIDTH(8))  bus_a ();
  bus_drive_sequencer_if #(.CHANNELS(3), .WIDTH(16)) bus_c ();

  bus_drive_sequencer #(.WIDTH(8), .CHANNELS(4), .TURNAROUND(1), .HOLD_MAX(4)) u_a (
    .clk(clk), .rst_n(rst_a), .bus(bus_a));
  bus_drive_sequencer #(.WIDTH(16), .CHANNELS(3), .TURNAROUND(3), .HOLD_MAX(0)) u_c (
    .clk(clk), .rst_n(rst_c), .bus(bus_c));

  typedef struct packed { logic [3:0] g; logic pre; } ea_t;
  typedef struct packed { logic [2:0] g; logic pre; } ec_t;
  ea_t qa[$];
  ec_t qc[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] drv_a(input logic [3:0] g);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = g[i] ? 8'hFF : 8'h00;
    return r;
  endfunction

  function automatic logic [47:0] drv_c(input logic [2:0] g);
    logic [47:0] r;
    for (int i = 0; i < 3; i++) r[i*16 +: 16] = g[i] ? 16'hFFFF : 16'h0000;
    return r;
  endfunction

  task automatic chk(input string nm, input int row, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask

  // Inputs applied at negedge take effect on the next rising edge; the
  // expected outputs for after that edge are queued at the same time.
  task automatic sa(input logic r, input logic [3:0] q, input logic [3:0] g, input logic pre);
    ea_t e;
    @(negedge clk);
    rst_a = r; bus_a.req = q;
    e.g = g; e.pre = pre;
    qa.push_back(e);
  endtask

  task automatic sc(input logic r, input logic [2:0] q, input logic [2:0] g);
    ec_t e;
    @(negedge clk);
    rst_c = r; bus_c.req = q;
    e.g = g; e.pre = 1'b0;
    qc.push_back(e);
  endtask

  initial begin : monitor
    int ra, rc;
    ea_t ea;
    ec_t ec;
    ra = 0; rc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() != 0) begin
        ea = qa.pop_front();
        chk("a_grant", ra, 64'(bus_a.grant), 64'(ea.g));
        chk("a_drive", ra, 64'(bus_a.drive), 64'(drv_a(ea.g)));
        chk("a_idle",  ra, 64'(bus_a.bus_idle), 64'(ea.g == 4'b0));
        chk("a_preempt", ra, 64'(bus_a.preempt), 64'(ea.pre));
        ra++;
      end
      if (qc.size() != 0) begin
        ec = qc.pop_front();
        chk("c_grant", rc, 64'(bus_c.grant), 64'(ec.g));
        chk("c_drive", rc, 64'(bus_c.drive), 64'(drv_c(ec.g)));
        chk("c_idle",  rc, 64'(bus_c.bus_idle), 64'(ec.g == 3'b0));
        chk("c_preempt", rc, 64'(bus_c.preempt), 64'(ec.pre));
        rc++;
      end
    end
  end

  initial begin : stim
    bus_a.req = '0;
    bus_c.req = '0;
    // Reset with all requesting, then first grant to channel 0.
    sa(0, 4'b1111, 4'b0000, 0);
    sa(0, 4'b1111, 4'b0000, 0);
    sa(1, 4'b1111, 4'b0001, 0);
    // Handoff 0 -> 2 with one turnaround cycle.
    sa(1, 4'b0101, 4'b0001, 0);
    sa(1, 4'b0100, 4'b0000, 0);
    sa(1, 4'b0100, 4'b0100, 0);
    sa(1, 4'b0000, 4'b0000, 0);
    sa(1, 4'b0000, 4'b0000, 0);
    // Reset clears pointer (would otherwise be 3).
    sa(0, 4'b0000, 4'b0000, 0);
    // Round-robin 0,1,3,0.
    sa(1, 4'b1011, 4'b0001, 0);
    sa(1, 4'b1011, 4'b0001, 0);
    sa(1, 4'b1011, 4'b0001, 0);
    sa(1, 4'b1010, 4'b0000, 0);
    sa(1, 4'b1011, 4'b0010, 0);
    sa(1, 4'b1011, 4'b0010, 0);
    sa(1, 4'b1011, 4'b0010, 0);
    sa(1, 4'b1001, 4'b0000, 0);
    sa(1, 4'b1011, 4'b1000, 0);
    sa(1, 4'b1011, 4'b1000, 0);
    sa(1, 4'b1011, 4'b1000, 0);
    sa(1, 4'b0011, 4'b0000, 0);
    sa(1, 4'b1011, 4'b0001, 0);
    sa(1, 4'b0000, 4'b0000, 0);
    sa(1, 4'b0000, 4'b0000, 0);
    // Preempt: ch1 drives 4 cycles while ch3 waits.
    sa(1, 4'b1010, 4'b0010, 0);
    sa(1, 4'b1010, 4'b0010, 0);
    sa(1, 4'b1010, 4'b0010, 0);
    sa(1, 4'b1010, 4'b0010, 0);
    sa(1, 4'b1010, 4'b0000, 1);
    sa(1, 4'b1010, 4'b1000, 0);
    sa(1, 4'b1000, 4'b1000, 0);
    // Reset mid-drive by ch2: drops immediately, no turnaround after.
    sa(1, 4'b0100, 4'b0000, 0);
    sa(1, 4'b0100, 4'b0100, 0);
    sa(1, 4'b0100, 4'b0100, 0);
    sa(0, 4'b0100, 4'b0000, 0);
    sa(1, 4'b1010, 4'b0010, 0);
    sa(1, 4'b0000, 4'b0000, 0);
    sa(1, 4'b0000, 4'b0000, 0);

    // Three channels, three turnaround cycles, pointer wrap.
    sc(0, 3'b000, 3'b000);
    sc(1, 3'b100, 3'b100);
    sc(1, 3'b101, 3'b100);
    sc(1, 3'b101, 3'b100);
    sc(1, 3'b001, 3'b000);
    sc(1, 3'b001, 3'b000);
    sc(1, 3'b001, 3'b000);
    sc(1, 3'b001, 3'b001);
    sc(1, 3'b011, 3'b001);
    sc(1, 3'b010, 3'b000);
    sc(1, 3'b010, 3'b000);
    sc(1, 3'b010, 3'b000);
    sc(1, 3'b010, 3'b010);
    sc(1, 3'b000, 3'b000);
    sc(1, 3'b000, 3'b000);
    sc(1, 3'b000, 3'b000);
    sc(1, 3'b000, 3'b000);
    sc(1, 3'b011, 3'b001);
    sc(1, 3'b000, 3'b000);

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (qa.size() != 0 || qc.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d entries left expected 0", qa.size() + qc.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
